csr_trap_unit: RTL and testbench

- Machine-mode CSR file and trap controller, generalised from the core's inline CSR/ecall/mret logic into a standalone parametrised block.
- It sits beside the single-cycle datapath. It serves Zicsr reads and writes, takes ecall/ebreak/illegal-CSR exceptions and timer/external interrupts, and performs proper mstatus MIE/MPIE stacking on trap and mret.
- It supplies the redirect PC to the PC register.

---
 rtl/csr_trap_pkg.sv | 56 +++++
 rtl/csr_counter.sv | 43 ++++
 rtl/csr_trap_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller.
// Contents:
//   - CSR address constants
//   - trap cause codes
//   - mstatus/mie/mip bit positions
//   - csr_op encoding (funct3[1:0])
//   - csr_apply(): the read-modify-write helper
package csr_trap_pkg;

   localparam logic [11:0] CsrMstatus   = 12'h300;
   localparam logic [11:0] CsrMie       = 12'h304;
   localparam logic [11:0] CsrMtvec     = 12'h305;
   localparam logic [11:0] CsrMscratch  = 12'h340;
   localparam logic [11:0] CsrMepc      = 12'h341;
   localparam logic [11:0] CsrMcause    = 12'h342;
   localparam logic [11:0] CsrMtval     = 12'h343;
   localparam logic [11:0] CsrMip       = 12'h344;
   localparam logic [11:0] CsrMcycle    = 12'hB00;
   localparam logic [11:0] CsrMinstret  = 12'hB02;
   localparam logic [11:0] CsrMcycleh   = 12'hB80;
   localparam logic [11:0] CsrMinstreth = 12'hB82;
   localparam logic [11:0] CsrMvendorid = 12'hF11;
   localparam logic [11:0] CsrMarchid   = 12'hF12;
   localparam logic [11:0] CsrMhartid   = 12'hF14;

   localparam logic [31:0] CauseIllegal  = 32'd2;
   localparam logic [31:0] CauseBreak    = 32'd3;
   localparam logic [31:0] CauseEcallM   = 32'd11;
   localparam logic [31:0] CauseIrqTimer = 32'h8000_0007;
   localparam logic [31:0] CauseIrqExt   = 32'h8000_000B;

   localparam int unsigned MstatusMie   = 3;
   localparam int unsigned MstatusMpie  = 7;
   localparam int unsigned MstatusMppLo = 11;
   localparam int unsigned MstatusMppHi = 12;
   localparam int unsigned IrqTimerBit  = 7;   // MTIE / MTIP
   localparam int unsigned IrqExtBit    = 11;  // MEIE / MEIP

   typedef enum logic [1:0] {
      CsrOpNone  = 2'b00,
      CsrOpWrite = 2'b01,
      CsrOpSet   = 2'b10,
      CsrOpClear = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                             input logic [31:0] src);
      case (op)
         CsrOpWrite: return src;
         CsrOpSet:   return old_val | src;
         CsrOpClear: return old_val & ~src;
         default:    return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter.sv
// Wide event counter exposed as two 32-bit CSR halves (low and high).
// Parameters:
//   Width     - counter width, 33..64
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc_i     - count one event this cycle
//   wr_lo_i   - CSR write to bits [31:0]
//   wr_hi_i   - CSR write to bits [Width-1:32]
//   wdata_i   - CSR write data
//   cnt_o     - current count
// A write to either half takes precedence over, and suppresses, the increment.
module csr_counter #(
   parameter int unsigned Width = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             wr_lo_i,
   input  logic             wr_hi_i,
   input  logic [31:0]      wdata_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) cnt_d[31:0] = wdata_i;
         if (wr_hi_i) cnt_d[Width-1:32] = (Width-32)'(wdata_i);
      end else if (inc_i) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller beside the single-cycle datapath.
// Functions:
//   - Zicsr reads and writes
//   - ecall/ebreak/illegal-CSR exceptions
//   - timer/external interrupts
//   - mret, with mstatus MIE/MPIE stacking on trap entry and return
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   retire_i, pc_i      - current instruction commits / its PC
//   csr_en_i            - current instruction is a CSR op
//   csr_op_i            - funct3[1:0]
//   csr_addr_i          - CSR number
//   csr_src_i           - rs1 value or zero-extended uimm
//   csr_src_zero_i      - rs1 index or uimm field is 0
//   ecall_i, ebreak_i, mret_i
//   irq_timer_i         - asynchronous machine interrupt request (timer)
//   irq_ext_i           - asynchronous machine interrupt request (external)
//   csr_rdata_o         - old CSR value (combinational from csr_addr_i)
//   redirect_o          - PC must load redirect_pc_o
//   redirect_pc_o       - trap vector or mepc
//   trap_taken_o        - trap entry this cycle
// Build option:
//   CSR_TRAP_VECTORED_EN - mtvec[0] writable; mode 01 vectors interrupts
//                          to base + 4*cause
module csr_trap_unit
   import csr_trap_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 64,
   parameter logic [31:0] MVENDORID   = 32'h7973_7978,
   parameter logic [31:0] MARCHID     = 32'h018C_E196,
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter logic [31:0] RESET_MTVEC = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            retire_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            csr_en_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_src_i,
   input  logic            csr_src_zero_i,
   input  logic            ecall_i,
   input  logic            ebreak_i,
   input  logic            mret_i,
   input  logic            irq_timer_i,
   input  logic            irq_ext_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            trap_taken_o
);

`ifdef CSR_TRAP_VECTORED_EN
   localparam logic [31:0] MtvecWrMask = 32'hFFFF_FFFD;
`else
   localparam logic [31:0] MtvecWrMask = 32'hFFFF_FFFC;
`endif

   logic [1:0]  irq_t_sync_q, irq_e_sync_q;
   logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
   logic        mie_mtie_q, mie_mtie_d, mie_meie_q, mie_meie_d;
   logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
   logic [CNT_W-1:0] mcycle, minstret;
   logic [63:0] mcycle_ext, minstret_ext;

   csr_op_e     op;
   logic        mip_mtip, mip_meip;
   logic [31:0] rdata, wdata, mepc_rd, trap_cause;
   logic        csr_known, csr_ro, csr_real_wr, csr_illegal, irq_pending, trap, csr_we, mret_take;

   assign op           = csr_op_e'(csr_op_i);
   assign mip_mtip     = irq_t_sync_q[1];
   assign mip_meip     = irq_e_sync_q[1];
   assign mepc_rd      = mepc_q & 32'hFFFF_FFFC;
   assign mcycle_ext   = 64'(mcycle);
   assign minstret_ext = 64'(minstret);

   // Read mux and address classification.
   always_comb begin
      rdata     = '0;
      csr_known = 1'b1;
      csr_ro    = 1'b0;
      case (csr_addr_i)
         CsrMstatus: begin
            rdata[MstatusMie]                = mstatus_mie_q;
            rdata[MstatusMpie]               = mstatus_mpie_q;
            rdata[MstatusMppHi:MstatusMppLo] = 2'b11;
         end
         CsrMie: begin
            rdata[IrqTimerBit] = mie_mtie_q;
            rdata[IrqExtBit]   = mie_meie_q;
         end
         CsrMtvec:     rdata = mtvec_q;
         CsrMscratch:  rdata = mscratch_q;
         CsrMepc:      rdata = mepc_rd;
         CsrMcause:    rdata = mcause_q;
         CsrMtval:     rdata = mtval_q;
         CsrMip: begin
            csr_ro             = 1'b1;
            rdata[IrqTimerBit] = mip_mtip;
            rdata[IrqExtBit]   = mip_meip;
         end
         CsrMcycle:    rdata = mcycle_ext[31:0];
         CsrMcycleh:   rdata = mcycle_ext[63:32];
         CsrMinstret:  rdata = minstret_ext[31:0];
         CsrMinstreth: rdata = minstret_ext[63:32];
         CsrMvendorid: begin csr_ro = 1'b1; rdata = MVENDORID; end
         CsrMarchid:   begin csr_ro = 1'b1; rdata = MARCHID;   end
         CsrMhartid:   begin csr_ro = 1'b1; rdata = HART_ID;   end
         default:      csr_known = 1'b0;
      endcase
   end

   assign csr_rdata_o = rdata;
   assign wdata       = csr_apply(op, rdata, csr_src_i);

   // csrrs/csrrc with x0/uimm=0 is a pure read, legal even on read-only CSRs.
   assign csr_real_wr = csr_en_i && ((op == CsrOpWrite) ||
                                     ((op inside {CsrOpSet, CsrOpClear}) && !csr_src_zero_i));
   assign csr_illegal = csr_en_i && (!csr_known || (csr_ro && csr_real_wr));
   assign irq_pending = mstatus_mie_q && ((mie_mtie_q && mip_mtip) || (mie_meie_q && mip_meip));

   always_comb begin
      trap       = 1'b1;
      trap_cause = '0;
      if (irq_pending)     trap_cause = (mie_meie_q && mip_meip) ? CauseIrqExt : CauseIrqTimer;
      else if (csr_illegal) trap_cause = CauseIllegal;
      else if (ebreak_i)    trap_cause = CauseBreak;
      else if (ecall_i)     trap_cause = CauseEcallM;
      else                  trap = 1'b0;
   end

   assign trap_taken_o = retire_i && trap;
   assign mret_take    = retire_i && mret_i && !trap;
   assign csr_we       = retire_i && csr_real_wr && !trap;
   assign redirect_o   = trap_taken_o || mret_take;

   always_comb begin
      redirect_pc_o = mtvec_q & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
      if (irq_pending && (mtvec_q[1:0] == 2'b01)) begin
         redirect_pc_o = (mtvec_q & 32'hFFFF_FFFC) + {26'd0, trap_cause[3:0], 2'b00};
      end
`endif
      if (mret_take) redirect_pc_o = mepc_rd;
   end

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_mtie_d     = mie_mtie_q;
      mie_meie_d     = mie_meie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      if (trap_taken_o) begin
         mepc_d         = pc_i;
         mcause_d       = trap_cause;
         mtval_d        = '0;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_take) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (csr_we) begin
         case (csr_addr_i)
            CsrMstatus: begin
               mstatus_mie_d  = wdata[MstatusMie];
               mstatus_mpie_d = wdata[MstatusMpie];
            end
            CsrMie: begin
               mie_mtie_d = wdata[IrqTimerBit];
               mie_meie_d = wdata[IrqExtBit];
            end
            CsrMtvec:    mtvec_d    = wdata & MtvecWrMask;
            CsrMscratch: mscratch_d = wdata;
            CsrMepc:     mepc_d     = wdata;
            CsrMcause:   mcause_d   = wdata;
            CsrMtval:    mtval_d    = wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_t_sync_q   <= '0;
         irq_e_sync_q   <= '0;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= RESET_MTVEC;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
      end else begin
         irq_t_sync_q   <= {irq_t_sync_q[0], irq_timer_i};
         irq_e_sync_q   <= {irq_e_sync_q[0], irq_ext_i};
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_mtie_q     <= mie_mtie_d;
         mie_meie_q     <= mie_meie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
      end
   end

   csr_counter #(.Width(CNT_W)) u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (1'b1),
      .wr_lo_i (csr_we && (csr_addr_i == CsrMcycle)),
      .wr_hi_i (csr_we && (csr_addr_i == CsrMcycleh)),
      .wdata_i (wdata),
      .cnt_o   (mcycle)
   );

   csr_counter #(.Width(CNT_W)) u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (retire_i && !trap_taken_o),
      .wr_lo_i (csr_we && (csr_addr_i == CsrMinstret)),
      .wr_hi_i (csr_we && (csr_addr_i == CsrMinstreth)),
      .wdata_i (wdata),
      .cnt_o   (minstret)
   );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios followed by random
// instruction streams, every cycle compared against a behavioural model.
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        retire, csr_en, csr_src_zero, ecall, ebreak, mret, irq_timer, irq_ext;
   logic [31:0] pc, csr_src, csr_rdata, redirect_pc;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic        redirect, trap_taken;

   int errors = 0;
   int checks = 0;

   // Model state
   bit          m_mie, m_mpie, m_mtie, m_meie;
   logic [31:0] m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cycle, m_instret;
   bit          hist_t[$], hist_e[$];

   always #5 clk = ~clk;

   csr_trap_unit dut (
      .clk            (clk),
      .rst            (rst),
      .retire_i       (retire),
      .pc_i           (pc),
      .csr_en_i       (csr_en),
      .csr_op_i       (csr_op),
      .csr_addr_i     (csr_addr),
      .csr_src_i      (csr_src),
      .csr_src_zero_i (csr_src_zero),
      .ecall_i        (ecall),
      .ebreak_i       (ebreak),
      .mret_i         (mret),
      .irq_timer_i    (irq_timer),
      .irq_ext_i      (irq_ext),
      .csr_rdata_o    (csr_rdata),
      .redirect_o     (redirect),
      .redirect_pc_o  (redirect_pc),
      .trap_taken_o   (trap_taken)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // An interrupt line reaches mip two clock edges after it is driven.
   function automatic bit mip_t();
      return (hist_t.size() >= 2) ? hist_t[hist_t.size()-2] : 1'b0;
   endfunction

   function automatic bit mip_e();
      return (hist_e.size() >= 2) ? hist_e[hist_e.size()-2] : 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a, output bit known);
      known = 1'b1;
      case (a)
         12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7) | (32'd3 << 11);
         12'h304: return (32'(m_mtie) << 7) | (32'(m_meie) << 11);
         12'h305: return m_mtvec;
         12'h340: return m_scratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return (32'(mip_t()) << 7) | (32'(mip_e()) << 11);
         12'hB00: return m_cycle[31:0];
         12'hB80: return m_cycle[63:32];
         12'hB02: return m_instret[31:0];
         12'hB82: return m_instret[63:32];
         12'hF11: return 32'h7973_7978;
         12'hF12: return 32'h018C_E196;
         12'hF14: return 32'h0;
         default: begin known = 1'b0; return 32'h0; end
      endcase
   endfunction

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
      m_mtvec = 32'h0; m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cycle = 0; m_instret = 0;
      hist_t.delete(); hist_e.delete();
   endtask

   task automatic idle();
      retire = 0; csr_en = 0; csr_op = 2'b00; csr_addr = 12'h0; csr_src = 0;
      csr_src_zero = 0; ecall = 0; ebreak = 0; mret = 0; pc = 0;
   endtask

   task automatic set_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
      idle();
      retire = 1; csr_en = 1; csr_op = op; csr_addr = a; csr_src = src;
      csr_src_zero = (src == 0);
   endtask

   // One clock cycle: compare outputs at the falling edge, advance the model, then
   // return #1 after the rising edge so the caller can drive the next cycle.
   task automatic tick();
      bit          known, ro, real_wr, ill, irq, trap, exp_trap, exp_redir, cyc_w, ins_w;
      logic [31:0] old, nv, cause, exp_pc;
      @(negedge clk);
      old     = m_read(csr_addr, known);
      ro      = csr_addr inside {12'hF11, 12'hF12, 12'hF14, 12'h344};
      real_wr = csr_en && ((csr_op == 2'b01) || !csr_src_zero);
      ill     = csr_en && (!known || (ro && real_wr));
      irq     = m_mie && ((m_mtie && mip_t()) || (m_meie && mip_e()));
      trap    = 1;
      cause   = 0;
      if (irq)         cause = (m_meie && mip_e()) ? 32'h8000_000B : 32'h8000_0007;
      else if (ill)    cause = 2;
      else if (ebreak) cause = 3;
      else if (ecall)  cause = 11;
      else             trap = 0;
      exp_trap  = retire && trap;
      exp_redir = exp_trap || (retire && mret);
      exp_pc    = m_mtvec & ~32'h3;
`ifdef CSR_TRAP_VECTORED_EN
      if (irq && m_mtvec[1:0] == 2'b01) exp_pc = exp_pc + 4 * (cause & 32'hF);
`endif
      if (!exp_trap) exp_pc = m_mepc;
      check_eq("csr_rdata", csr_rdata, old);
      check_eq("trap_taken", trap_taken, exp_trap);
      check_eq("redirect", redirect, exp_redir);
      if (exp_redir) check_eq("redirect_pc", redirect_pc, exp_pc);

      case (csr_op)
         2'b01:   nv = csr_src;
         2'b10:   nv = old | csr_src;
         default: nv = old & ~csr_src;
      endcase
      cyc_w = 0;
      ins_w = 0;
      if (exp_trap) begin
         m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = 0; m_mpie = m_mie; m_mie = 0;
      end else if (retire && mret) begin
         m_mie = m_mpie; m_mpie = 1;
      end else if (retire && real_wr) begin
         case (csr_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
`ifdef CSR_TRAP_VECTORED_EN
            12'h305: m_mtvec = nv & ~32'h2;
`else
            12'h305: m_mtvec = nv & ~32'h3;
`endif
            12'h340: m_scratch = nv;
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            12'hB00: begin m_cycle[31:0] = nv; cyc_w = 1; end
            12'hB80: begin m_cycle[63:32] = nv; cyc_w = 1; end
            12'hB02: begin m_instret[31:0] = nv; ins_w = 1; end
            12'hB82: begin m_instret[63:32] = nv; ins_w = 1; end
            default: ;
         endcase
      end
      if (!cyc_w) m_cycle = m_cycle + 1;
      if (!ins_w && retire && !exp_trap) m_instret = m_instret + 1;
      hist_t.push_back(irq_timer);
      hist_e.push_back(irq_ext);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
      idle();
      csr_addr = a;
      #2;
      check_eq(tag, csr_rdata, exp);
      tick();
   endtask

   task automatic do_reset();
      rst = 1;
      idle();
      irq_timer = 0;
      irq_ext = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   logic [11:0] addr_tab[16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hF11, 12'hF12, 12'hF14, 12'h7C0};

   initial begin
      logic [31:0] hi, ins;
      int          kind;
      do_reset();

      // Reset state
      expect_read("rst_mvendorid", 12'hF11, 32'h7973_7978);
      expect_read("rst_mtvec", 12'h305, 32'h0);
      expect_read("rst_mstatus", 12'h300, 32'h1800);
      expect_read("rst_mcause", 12'h342, 32'h0);

      // ecall then mret
      set_csr(2'b01, 12'h305, 32'h8000_0100); tick();
      idle(); retire = 1; ecall = 1; pc = 32'h8000_0010; #2;
      check_eq("ecall_taken", trap_taken, 1'b1);
      check_eq("ecall_vec", redirect_pc, 32'h8000_0100);
      tick();
      expect_read("ecall_mepc", 12'h341, 32'h8000_0010);
      expect_read("ecall_mcause", 12'h342, 32'd11);
      expect_read("ecall_mstatus", 12'h300, 32'h1800);
      idle(); retire = 1; mret = 1; #2;
      check_eq("mret_redirect", redirect, 1'b1);
      check_eq("mret_pc", redirect_pc, 32'h8000_0010);
      tick();

      // Timer interrupt lands on the third retire after assertion
      set_csr(2'b10, 12'h300, 32'h8); tick();
      set_csr(2'b10, 12'h304, 32'h80); tick();
      irq_timer = 1;
      for (int i = 0; i < 3; i++) begin
         idle(); retire = 1; pc = 32'h8000_0200 + 4 * i; #2;
         check_eq("irq_latency", trap_taken, (i == 2));
         tick();
      end
      irq_timer = 0;
      expect_read("irq_mcause", 12'h342, 32'h8000_0007);
      expect_read("irq_mstatus", 12'h300, 32'h1880);
      idle(); retire = 1; mret = 1; tick();
      expect_read("irq_mret_mstatus", 12'h300, 32'h1888);

      // Both interrupts: external wins; vectored base when enabled
      set_csr(2'b01, 12'h305, 32'h8000_0101); tick();
      set_csr(2'b10, 12'h304, 32'h800); tick();
      irq_timer = 1; irq_ext = 1;
      idle(); tick(); tick();
      retire = 1; #2;
      check_eq("irq_both_taken", trap_taken, 1'b1);
`ifdef CSR_TRAP_VECTORED_EN
      check_eq("irq_vectored_pc", redirect_pc, 32'h8000_012C);
`else
      check_eq("irq_direct_pc", redirect_pc, 32'h8000_0100);
`endif
      tick();
      irq_timer = 0; irq_ext = 0;
      expect_read("irq_both_mcause", 12'h342, 32'h8000_000B);
      idle(); tick(); tick();

      // mcycle carry into the high half
      hi = m_cycle[63:32];
      set_csr(2'b01, 12'hB00, 32'hFFFF_FFFE); tick();
      idle(); tick(); tick();
      expect_read("mcycle_wrap_lo", 12'hB00, 32'h0);
      expect_read("mcycle_carry_hi", 12'hB80, hi + 1);
      set_csr(2'b10, 12'hF11, 32'h0); #2;
      check_eq("csrrs_ro_x0_legal", trap_taken, 1'b0);
      tick();

      // Illegal CSR accesses
      ins = m_instret[31:0];
      set_csr(2'b01, 12'hF11, 32'hDEAD); #2;
      check_eq("ro_write_trap", trap_taken, 1'b1);
      tick();
      expect_read("ro_write_mcause", 12'h342, 32'd2);
      expect_read("ro_write_unchanged", 12'hF11, 32'h7973_7978);
      expect_read("ro_write_minstret", 12'hB02, ins);
      expect_read("ro_write_mtval", 12'h343, 32'h0);
      set_csr(2'b01, 12'h342, 32'h0); tick();
      set_csr(2'b01, 12'h7C0, 32'h5); #2;
      check_eq("unknown_trap", trap_taken, 1'b1);
      tick();
      expect_read("unknown_mcause", 12'h342, 32'd2);
      set_csr(2'b01, 12'h340, 32'h1234_5678); tick();

      // Random instruction stream with one asynchronous reset in the middle
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            rst = 1;
            idle();
            csr_addr = 12'h340;
            #2;
            check_eq("async_rst_mscratch", csr_rdata, 32'h0);
            do_reset();
         end
         idle();
         retire   = ($urandom_range(3) != 0);
         pc       = $urandom;
         csr_addr = addr_tab[$urandom_range(15)];
         kind     = $urandom_range(7);
         if (kind < 4) begin
            csr_en       = 1;
            csr_op       = 2'($urandom_range(3, 1));
            csr_src      = $urandom;
            csr_src_zero = ($urandom_range(3) == 0);
         end else if (kind == 4) ecall = 1;
         else if (kind == 5) ebreak = 1;
         else if (kind == 6) mret = 1;
         if ($urandom_range(15) == 0) irq_timer = ~irq_timer;
         if ($urandom_range(15) == 0) irq_ext = ~irq_ext;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
